uart_tx_fifo: RTL and testbench

- Buffered UART transmitter with break generation, for the host-facing serial link.
- Framing is 8N1, LSB first, with a bit period of 2*BAUDSEL+1 clocks, matching the bootloader's UART receiver.
- Bytes are queued in a FIFO and sent back-to-back without idle gaps.
- A break request drives the line low long enough to trigger the receiver's break detection, then restores mark.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_fifo_byte_fifo.sv | 58 +++++
 rtl/uart_tx_fifo.sv | 205 ++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the buffered UART transmitter.
//   tx_state_t  - transmitter FSM states
//   DATA_BITS   - data bits per frame (8N1 framing)
//   MAB_BITS    - mark-after-break length in bit periods
//   bit_period  - clocks per bit for a given BAUDSEL
package uart_pkg;

   localparam int DATA_BITS = 8;
   localparam int MAB_BITS  = 2;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK,
      MAB
   } tx_state_t;

   // The bootloader's receiver uses odd bit periods so it can sample the exact centre.
   function automatic int bit_period(input int baudsel);
      return 2 * baudsel + 1;
   endfunction

endpackage

// File: rtl/uart_tx_fifo_byte_fifo.sv
// byte_fifo: synchronous byte FIFO with show-ahead read data.
// Ports:
//   clk, reset  - clock and synchronous active-high reset (flushes the FIFO)
//   wr_en       - write wr_data; accepted when not full, or when full and popping
//   wr_data     - byte to store
//   rd_en       - pop the head entry (ignored when empty)
//   rd_data     - head entry, valid whenever empty is low
//   full, empty - occupancy flags
//   level       - number of stored entries (0..DEPTH)
module byte_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [7:0]               wr_data,
   input  logic                     rd_en,
   output logic [7:0]               rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

   logic [7:0]  r_mem [DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic        w_wr;
   logic        w_rd;

   // Pointers carry one extra bit so full and empty differ without a separate flag.
   assign level   = r_wr_ptr - r_rd_ptr;
   assign full    = (level == FULL_LEVEL);
   assign empty   = (r_wr_ptr == r_rd_ptr);
   assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

   assign w_rd = rd_en && !empty;
   assign w_wr = wr_en && (!full || w_rd);

   // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // NOTE: storage has no reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter (LSB first) with break generation.
// Bit period is 2*BAUDSEL+1 clocks; queued bytes are sent back-to-back.
// Ports:
//   clk, reset     - clock and synchronous active-high reset
//   tx_valid       - byte offered on tx_data; taken when tx_valid && tx_ready
//   tx_data        - byte to send
//   tx_ready       - FIFO can accept a byte (low while reset is high)
//   break_req      - one-cycle break request pulse
//   break_pending  - break latched or in progress
//   fifo_level     - bytes queued, excluding the byte being shifted
//   busy           - FSM active or FIFO non-empty
//   tx             - registered serial line, idle high
// Build option: define UART_TX_BREAK_EN to include break generation (BREAK and
// MAB states). Without it break_req is ignored and break_pending reads 0.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int BAUDSEL    = 10,
   parameter int FIFO_DEPTH = 16,
   parameter int BREAK_BITS = 12
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          tx_valid,
   input  logic [7:0]                    tx_data,
   output logic                          tx_ready,
   input  logic                          break_req,
   output logic                          break_pending,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          busy,
   output logic                          tx
);

   localparam int CNT_W   = $clog2(bit_period(BAUDSEL) + 1);
   localparam int IDX_MAX = (BREAK_BITS > DATA_BITS) ? BREAK_BITS : DATA_BITS;
   localparam int IDX_W   = $clog2(IDX_MAX + 1);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(bit_period(BAUDSEL) - 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
`ifdef UART_TX_BREAK_EN
   localparam logic [IDX_W-1:0] BREAK_LAST = IDX_W'(BREAK_BITS - 1);
   localparam logic [IDX_W-1:0] MAB_LAST   = IDX_W'(MAB_BITS - 1);
`endif

   tx_state_t              r_state;
   logic [CNT_W-1:0]       r_bit_cnt;
   logic [IDX_W-1:0]       r_bit_idx;
   logic [DATA_BITS-1:0]   r_shift;
   logic                   r_tx;
   logic                   r_ready;
   logic                   r_break_pending;

   logic                   w_bit_end;
   logic                   w_frame_edge;
   logic                   w_take_break;
   logic                   w_pop;
   logic                   w_full;
   logic                   w_empty;
   logic [7:0]             w_rd_data;
   logic                   w_tx_next;

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (tx_valid && tx_ready),
      .wr_data (tx_data),
      .rd_en   (w_pop),
      .rd_data (w_rd_data),
      .full    (w_full),
      .empty   (w_empty),
      .level   (fifo_level)
   );

   assign w_bit_end = (r_bit_cnt == CNT_LAST);

   // A frame boundary is IDLE or the last clock of STOP; both make the same decision
   // so consecutive frames run with no idle gap.
   assign w_frame_edge = (r_state == IDLE) || ((r_state == STOP) && w_bit_end);

`ifdef UART_TX_BREAK_EN
   assign w_take_break = w_frame_edge && r_break_pending;
`else
   logic w_unused_break_req;
   assign w_unused_break_req = break_req;
   assign w_take_break       = 1'b0;
`endif

   // A latched break outranks queued bytes; those bytes stay in the FIFO.
   assign w_pop = w_frame_edge && !w_take_break && !w_empty;

   assign tx_ready      = r_ready && !w_full;
   assign busy          = (r_state != IDLE) || !w_empty;
   assign tx            = r_tx;
   assign break_pending = r_break_pending;

   // tx_ready stays low for the whole reset and rises on the first edge after it.
   always_ff @(posedge clk) begin
      if (reset) r_ready <= 1'b0;
      else       r_ready <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_bit_cnt <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
      end else begin
         // The bit counter free-runs in every active state and wraps at each bit end.
         r_bit_cnt <= ((r_state == IDLE) || w_bit_end) ? '0 : r_bit_cnt + 1'b1;
         case (r_state)
            IDLE: begin
               if (w_take_break) begin
                  r_state   <= BREAK;
                  r_bit_idx <= '0;
               end else if (w_pop) begin
                  r_shift <= w_rd_data;
                  r_state <= START;
               end
            end
            START: begin
               if (w_bit_end) begin
                  r_state   <= DATA;
                  r_bit_idx <= '0;
               end
            end
            DATA: begin
               if (w_bit_end) begin
                  r_shift <= r_shift >> 1;
                  if (r_bit_idx == DATA_LAST) r_state <= STOP;
                  else                        r_bit_idx <= r_bit_idx + 1'b1;
               end
            end
            STOP: begin
               if (w_bit_end) begin
                  if (w_take_break) begin
                     r_state   <= BREAK;
                     r_bit_idx <= '0;
                  end else if (w_pop) begin
                     r_shift <= w_rd_data;
                     r_state <= START;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
`ifdef UART_TX_BREAK_EN
            BREAK: begin
               if (w_bit_end) begin
                  if (r_bit_idx == BREAK_LAST) begin
                     r_state   <= MAB;
                     r_bit_idx <= '0;
                  end else begin
                     r_bit_idx <= r_bit_idx + 1'b1;
                  end
               end
            end
            MAB: begin
               if (w_bit_end) begin
                  if (r_bit_idx == MAB_LAST) r_state <= IDLE;
                  else                       r_bit_idx <= r_bit_idx + 1'b1;
               end
            end
`endif
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef UART_TX_BREAK_EN
   // Requests arriving while a break is already pending are dropped, never queued.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_break_pending <= 1'b0;
      end else if (break_req && !r_break_pending) begin
         r_break_pending <= 1'b1;
      end else if ((r_state == MAB) && w_bit_end && (r_bit_idx == MAB_LAST)) begin
         r_break_pending <= 1'b0;
      end
   end
`else
   assign r_break_pending = 1'b0;
`endif

   // NOTE: always_comb assigns a default first so no path can infer a latch.
   always_comb begin
      w_tx_next = 1'b1;
      case (r_state)
         START:   w_tx_next = 1'b0;
         DATA:    w_tx_next = r_shift[0];
`ifdef UART_TX_BREAK_EN
         BREAK:   w_tx_next = 1'b0;
`endif
         default: w_tx_next = 1'b1;
      endcase
   end

   // The line is a flop fed by the state decode, so it never glitches and trails the
   // FSM by one clock: a byte written at edge k shows its start bit after edge k+2.
   always_ff @(posedge clk) begin
      if (reset) r_tx <= 1'b1;
      else       r_tx <= w_tx_next;
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo with BAUDSEL=2
// (5-clock bits, 50-clock frames). A reference receiver decodes the line and
// compares each byte against a scoreboard queue filled as bytes are accepted.
module tb_uart_tx_fifo;

   localparam int P     = 5;
   localparam int FRAME = 10 * P;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       break_req = 1'b0;
   logic       tx_ready;
   logic       break_pending;
   logic [4:0] fifo_level;
   logic       busy;
   logic       tx;

   uart_tx_fifo #(
      .BAUDSEL    (2),
      .FIFO_DEPTH (16),
      .BREAK_BITS (12)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .tx_valid      (tx_valid),
      .tx_data       (tx_data),
      .tx_ready      (tx_ready),
      .break_req     (break_req),
      .break_pending (break_pending),
      .fifo_level    (fifo_level),
      .busy          (busy),
      .tx            (tx)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] sb[$];
   int         start_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference receiver and line monitor ----------------
   logic       rx_en = 1'b0;
   logic       rx_active = 1'b0;
   logic       rx_last = 1'b1;
   logic [7:0] rx_byte = 8'h00;
   int         rx_cnt = 0;
   int         rx_bytes = 0;
   int         rx_break_cnt = 0;
   int         run_lo = 0;
   int         run_hi = 0;
   int         last_long_low = 0;
   int         mab_len = 0;
   logic       mab_track = 1'b0;

   initial begin : rx_model
      forever begin
         @(negedge clk);
         if (tx === 1'b0) begin
            if (mab_track && run_hi > 0) begin
               mab_len   = run_hi;
               mab_track = 1'b0;
            end
            run_hi = 0;
            run_lo++;
         end else begin
            if (run_lo >= 50) begin
               last_long_low = run_lo;
               mab_track     = 1'b1;
            end
            run_lo = 0;
            run_hi++;
         end

         if (!rx_en) begin
            rx_active = 1'b0;
         end else if (!rx_active) begin
            if (rx_last && !tx) begin
               rx_active = 1'b1;
               rx_cnt    = 0;
               start_q.push_back(cyc);
            end
         end else begin
            rx_cnt++;
            if (rx_cnt == 2 && tx) begin
               rx_active = 1'b0;
            end else if (rx_cnt >= 7 && rx_cnt <= 42 && (rx_cnt - 7) % P == 0) begin
               rx_byte = {tx, rx_byte[7:1]};
            end else if (rx_cnt == 47) begin
               rx_active = 1'b0;
               if (tx) begin
                  rx_bytes++;
                  if (sb.size() == 0) begin
                     n_tests++;
                     n_fail++;
                     $display("FAIL rx_unexpected: got byte 0x%0h, expected no byte", rx_byte);
                  end else begin
                     check("rx_byte", rx_byte, sb.pop_front());
                  end
               end else if (rx_byte == 8'h00) begin
                  rx_break_cnt++;
               end else begin
                  check("rx_stop_bit", tx, 1);
               end
            end
         end
         rx_last = tx;
      end
   end

   logic mon_en = 1'b0;
   logic in_overfill = 1'b0;
   logic full_seen = 1'b0;
   int   inv_err = 0;
   int   lvl_peak = 0;
   int   lvl_min = 99;

   initial begin : level_monitor
      forever begin
         @(negedge clk);
         if (mon_en && !reset) begin
            if (tx_ready !== (fifo_level != 5'd16)) inv_err++;
            if (fifo_level > 5'd16) inv_err++;
            if (int'(fifo_level) > lvl_peak) lvl_peak = int'(fifo_level);
            if (fifo_level == 5'd16) full_seen = 1'b1;
            if (in_overfill && int'(fifo_level) < lvl_min) lvl_min = int'(fifo_level);
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus helpers ----------------
   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [7:0] d);
      int guard = 0;
      tx_valid = 1'b1;
      tx_data  = d;
      while (!tx_ready && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      check("send_ready_timeout", guard < 2000, 1);
      sb.push_back(d);
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int limit);
      int n = 0;
      while ((sb.size() != 0 || busy || rx_active) && n < limit) begin
         @(negedge clk);
         n++;
      end
      check(name, n < limit, 1);
      repeat (3) @(negedge clk);
   endtask

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;   // expected line level per bit period, index 0 = start bit
   } vec_t;

   vec_t vecs[5];

   initial begin : main
      int n0;
      int b0;
      int s0;
      int low_cnt;
      int pend_cnt;

      vecs[0] = '{8'hA5, 10'b1_1010_0101_0};
      vecs[1] = '{8'h00, 10'b1_0000_0000_0};
      vecs[2] = '{8'hFF, 10'b1_1111_1111_0};
      vecs[3] = '{8'h3C, 10'b1_0011_1100_0};
      vecs[4] = '{8'h81, 10'b1_1000_0001_0};

      // ---- reset ----
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_ready_low", tx_ready, 0);
      check("rst_level", fifo_level, 0);
      check("rst_busy", busy, 0);
      check("rst_break_pending", break_pending, 0);
      reset = 1'b0;
      @(negedge clk);
      check("rst_ready_after", tx_ready, 1);
      check("rst_tx_after", tx, 1);
      rx_en  = 1'b1;
      mon_en = 1'b1;

      // ---- single bytes from the vector table ----
      for (int v = 0; v < 5; v++) begin
         @(negedge clk);
         tx_valid = 1'b1;
         tx_data  = vecs[v].data;
         @(negedge clk);
         tx_valid = 1'b0;
         sb.push_back(vecs[v].data);
         for (int j = 1; j <= 52; j++) begin
            @(negedge clk);
            if (j == 1) check("latency_still_idle", tx, 1);
            if (j == 2) check("latency_start_low", tx, 0);
            if (j >= 2 && (j - 2) % P == 2)
               check($sformatf("vec%0d_bit%0d", v, (j - 2) / P), tx, vecs[v].frame[(j - 2) / P]);
            if (j == 50) check("busy_in_stop", busy, 1);
            if (j == 51) check("busy_clear", busy, 0);
         end
      end

      // ---- back-to-back ----
      lvl_peak = 0;
      s0 = start_q.size();
      @(negedge clk);
      send(8'h00);
      send(8'hFF);
      send(8'h55);
      wait_drain("b2b_drain", 400);
      check("b2b_level_peak", lvl_peak, 2);
      check("b2b_frames", start_q.size() - s0, 3);
      if (start_q.size() - s0 == 3) begin
         check("b2b_gap_1", start_q[s0 + 1] - start_q[s0], FRAME);
         check("b2b_gap_2", start_q[s0 + 2] - start_q[s0 + 1], FRAME);
      end

      // ---- fill past full ----
      n0 = rx_bytes;
      full_seen = 1'b0;
      lvl_peak = 0;
      lvl_min = 99;
      @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         send(8'(8'h40 + i));
         if (full_seen) in_overfill = 1'b1;
      end
      in_overfill = 1'b0;
      wait_drain("full_drain", 3000);
      check("full_seen", full_seen, 1);
      check("full_peak", lvl_peak, 16);
      check("full_refill_min", lvl_min, 15);
      check("full_bytes", rx_bytes - n0, 20);
      check("full_ready_invariant", inv_err, 0);

`ifdef UART_TX_BREAK_EN
      // ---- break during a frame, byte queued behind it ----
      n0 = rx_bytes;
      b0 = rx_break_cnt;
      last_long_low = 0;
      mab_len = 0;
      mab_track = 1'b0;
      @(negedge clk);
      send(8'h3C);
      send(8'h11);
      repeat (20) @(negedge clk);
      break_req = 1'b1;
      @(negedge clk);
      break_req = 1'b0;
      check("brk_pending_set", break_pending, 1);
      repeat (3) @(negedge clk);
      break_req = 1'b1;
      @(negedge clk);
      break_req = 1'b0;
      wait_drain("brk_drain", 1000);
      check("brk_count", rx_break_cnt - b0, 1);
      check("brk_low_len", last_long_low, 12 * P);
      check("brk_mab_len_ok", mab_len >= 2 * P && mab_len <= 2 * P + 1, 1);
      check("brk_bytes", rx_bytes - n0, 2);
      check("brk_pending_clear", break_pending, 0);

      // ---- break together with a byte, then reset 20 clocks into BREAK ----
      rx_en = 1'b0;
      mon_en = 1'b0;
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data = 8'h77;
      break_req = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      break_req = 1'b0;
      check("brkv_pending", break_pending, 1);
      check("brkv_level", fifo_level, 1);
      @(negedge clk);
      check("brkv_byte_kept", fifo_level, 1);
      @(negedge clk);
      check("brkv_line_low", tx, 0);
      repeat (20) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rstbrk_tx", tx, 1);
      check("rstbrk_level", fifo_level, 0);
      check("rstbrk_pending", break_pending, 0);
      check("rstbrk_busy", busy, 0);
      reset = 1'b0;
      @(negedge clk);
      check("rstbrk_ready", tx_ready, 1);
`else
      // ---- break logic absent: requests never touch the line ----
      low_cnt = 0;
      pend_cnt = 0;
      @(negedge clk);
      break_req = 1'b1;
      @(negedge clk);
      break_req = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) low_cnt++;
         if (break_pending !== 1'b0) pend_cnt++;
      end
      check("nobrk_line_high", low_cnt, 0);
      check("nobrk_pending", pend_cnt, 0);
`endif

      // ---- reset mid-frame flushes queued bytes ----
      rx_en = 1'b0;
      mon_en = 1'b0;
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data = 8'h00;
      @(negedge clk);
      tx_data = 8'h99;
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (15) @(negedge clk);
      check("midrst_line_low", tx, 0);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_tx", tx, 1);
      check("midrst_level", fifo_level, 0);
      check("midrst_busy", busy, 0);
      reset = 1'b0;
      @(negedge clk);
      check("midrst_ready", tx_ready, 1);
      repeat (60) @(negedge clk);
      check("midrst_stays_idle", tx, 1);
      check("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
